// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two requesters share one external ALU.
// Each grant issues one operation, waits one cycle for the ALU, and then holds the result until it is accepted.
`timescale 1ns/1ps
module alu_arbiter #(
    parameter int DW = 32,
    parameter int RW = 64,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic [3:0]    req0_sel,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    input  logic [3:0]    req1_sel,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [RW-1:0] rsp0_data,
    output logic          rsp0_carry,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [RW-1:0] rsp1_data,
    output logic          rsp1_carry,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_sel,
    input  logic [RW-1:0] alu_out,
    input  logic          alu_carry,
    output logic          busy,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_id;
    logic          r_lastGrant;
    logic [DW-1:0] r_aluA;
    logic [DW-1:0] r_aluB;
    logic [3:0]    r_aluSel;
    logic [RW-1:0] r_data;
    logic          r_carry;
    logic [CW-1:0] r_cnt0;
    logic [CW-1:0] r_cnt1;
    logic          w_grant0;
    logic          w_grant1;
    logic          w_rspDone;

    // r_lastGrant resets to 1 so that requester 0 wins the first tie.
    assign w_grant0 = req0_valid & (~req1_valid | r_lastGrant);
    assign w_grant1 = req1_valid & (~req0_valid | ~r_lastGrant);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        w_rspDone  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!rst) begin
                    req0_ready = w_grant0;
                    req1_ready = w_grant1;
                    if (w_grant0 || w_grant1) begin
                        w_next = EXEC;
                    end
                end
            end
            EXEC: begin
                w_next = RESP;
            end
            RESP: begin
                rsp0_valid = ~r_id;
                rsp1_valid = r_id;
                w_rspDone  = r_id ? rsp1_ready : rsp0_ready;
                if (w_rspDone) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operands are latched only on a grant, so the ALU inputs stay put between operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id        <= 1'b0;
            r_lastGrant <= 1'b1;
            r_aluA      <= '0;
            r_aluB      <= '0;
            r_aluSel    <= '0;
            r_data      <= '0;
            r_carry     <= 1'b0;
            r_cnt0      <= '0;
            r_cnt1      <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_id     <= w_grant1;
                        r_aluA   <= w_grant1 ? req1_a   : req0_a;
                        r_aluB   <= w_grant1 ? req1_b   : req0_b;
                        r_aluSel <= w_grant1 ? req1_sel : req0_sel;
                    end
                end
                EXEC: begin
                    r_data  <= alu_out;
                    r_carry <= alu_carry;
                end
                RESP: begin
                    if (w_rspDone) begin
                        r_lastGrant <= r_id;
                        if (!r_id && (r_cnt0 != '1)) begin
                            r_cnt0 <= r_cnt0 + CW'(1);
                        end
                        if (r_id && (r_cnt1 != '1)) begin
                            r_cnt1 <= r_cnt1 + CW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign alu_a      = r_aluA;
    assign alu_b      = r_aluB;
    assign alu_sel    = r_aluSel;
    assign rsp0_data  = r_data;
    assign rsp1_data  = r_data;
    assign rsp0_carry = r_carry;
    assign rsp1_carry = r_carry;
    assign busy       = (r_state != IDLE);
    assign cnt0       = r_cnt0;
    assign cnt1       = r_cnt1;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DW, default 32, SHALL set the operand width.
REQ-003 Parameter RW, default 64, SHALL set the result width (2*DW).
REQ-004 Parameter CW, default 16, SHALL set the completion-counter width.
REQ-005 Port clk  input  1  SHALL be the rising-edge clock.
REQ-006 Port rst  input  1  SHALL be the asynchronous active-high reset.
REQ-007 Ports reqN_valid  input  1, reqN_ready  output  1 (N=0,1) SHALL form the request handshakes.
REQ-008 Ports reqN_a, reqN_b  input  DW; reqN_sel  input  4 SHALL carry the request operands and opcode.
REQ-009 Ports rspN_valid  output  1, rspN_ready  input  1 SHALL form the response handshakes.
REQ-010 Ports rspN_data  output  RW; rspN_carry  output  1 SHALL carry the returned result.
REQ-011 Ports alu_a, alu_b  output  DW; alu_sel  output  4 SHALL drive the shared ALU.
REQ-012 Ports alu_out  input  RW; alu_carry  input  1 SHALL return the ALU result and carry.
REQ-013 Port busy  output  1 SHALL be high whenever the state is not IDLE.
REQ-014 Ports cntN  output  CW SHALL report the completed transactions per requester.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC and RESP, held in registers.
REQ-016 In IDLE, if any reqN_valid is high, the block SHALL grant exactly one requester and assert only its reqN_ready, combinationally, in the same cycle.
REQ-017 Arbitration SHALL be round-robin:
- single valid requester: it wins;
- both valid: the requester not granted last wins;
- after reset, requester 0 wins a tie.
REQ-018 On grant, the block SHALL register reqN_a/b/sel into alu_a/b/sel, record the grant id, and enter EXEC.
REQ-019 EXEC SHALL last exactly one cycle, then the block SHALL capture alu_out and alu_carry into the result registers and enter RESP.
REQ-020 In RESP, rspN_valid SHALL be high only for the recorded id.
REQ-021 In RESP, rspN_data and rspN_carry SHALL hold stable until the cycle rspN_ready is high.
REQ-022 On that rspN_ready cycle, the block SHALL:
- update the last-grant pointer to the recorded id;
- increment cntN;
- return to IDLE.
REQ-023 Latency SHALL be fixed: a handshake at cycle T SHALL produce rspN_valid high at T+2, and minimum spacing between grants SHALL be 3 cycles.
REQ-024 reqN_ready SHALL be low in EXEC and RESP, so new requests stall there.
REQ-025 alu_a/b/sel SHALL hold their last issued values outside grant cycles.
REQ-026 The block SHALL pass the carry captured from alu_carry unmodified, without interpreting the opcode.
REQ-027 cntN SHALL saturate at all-ones and SHALL NOT wrap.
REQ-028 A response-side stall (rspN_ready low) SHALL be held indefinitely with no timeout, and the other requester SHALL remain blocked.
REQ-029 Requesters SHALL hold valid and operands stable until ready; the block SHALL NOT check this.

Reset
REQ-030 On rst high, the following SHALL clear asynchronously:
- state to IDLE;
- pointer to favour requester 0;
- alu_a, alu_b, alu_sel to 0;
- result registers to 0;
- all ready, valid and busy outputs to 0;
- cnt0 and cnt1 to 0.
REQ-031 Reset in EXEC or RESP SHALL abort the transaction, produce no response and leave the counters unchanged (cleared).
REQ-032 After rst falls, the first grant SHALL NOT occur before the first rising clk edge.

Verification
REQ-033 Single add: req0 a=0xFFFFFFFF b=1 sel=0000 with the ALU model attached -> req0_ready in cycle T; rsp0_valid at T+2; rsp0_data equals the model's result for the captured operands; rsp0_carry equals the captured alu_carry; cnt0=1.
REQ-034 Contention: both valid from reset, rsp ready held high -> grants in order 0,1,0,1, each grant 3 cycles apart; cnt0=2, cnt1=2.
REQ-035 Multiply with stall: req1 a=0x10000 b=0x10000 sel=0111, rsp1_ready low 5 cycles -> rsp1_data=0x100000000 held stable for all 5 cycles; req0 asserted meanwhile sees ready=0 until return to IDLE.
REQ-036 Reset mid-op: rst asserted in RESP -> all outputs 0 immediately; no rsp handshake; cnt0=cnt1=0; the next tie goes to requester 0.
REQ-037 Saturation: with CW=2, five req0 transactions -> cnt0 reads 3 and stays 3.
REQ-038 Idle hold: no requests for 10 cycles after a transaction -> busy=0 and alu_a/b/sel unchanged from the last issue.
